// File: rtl/tb_axil_mem_slave_if.sv
// AXI4-Lite bus bundle used between a master under test and the
// tb_axil_mem_slave memory model. Clock and reset are kept outside.
interface tb_axil_mem_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
    input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
    input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/tb_axil_mem_slave.sv
// AXI4-Lite slave model with a backing word memory. AW and W are latched
// independently, written per byte strobe, and reads return after RD_LAT
// cycles. All outputs come straight from registers.
// Optional build macro TB_AXIL_MEM_ERR_EN: out-of-range accesses answer
// SLVERR (writes dropped, reads return zero) instead of wrapping.
// The memory array carries no reset so its contents survive ARESETN.
module tb_axil_mem_slave #(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int unsigned       RD_LAT = 1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  tb_axil_mem_slave_if.slave s_axi
);

  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned OFF_W       = $clog2(STRB_W);
  localparam int unsigned IDX_W       = $clog2(DEPTH);
  localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LAT - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [0:0]  W_IDLE      = 1'b0;
  localparam logic [0:0]  W_RESP      = 1'b1;
  localparam logic [1:0]  R_IDLE      = 2'd0;
  localparam logic [1:0]  R_WAIT      = 2'd1;
  localparam logic [1:0]  R_DATA      = 2'd2;
`ifdef TB_AXIL_MEM_ERR_EN
  localparam logic        ERR_EN      = 1'b1;
`else
  localparam logic        ERR_EN      = 1'b0;
`endif

  // Word offset from BASE, full address width (upper bits flag out-of-range)
  function automatic logic [ADDR_W-1:0] word_off(input logic [ADDR_W-1:0] addr);
    return (addr - BASE) >> OFF_W;
  endfunction

  // Replace the strobed byte lanes of old_w with those of new_w
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
      else         res[8*b +: 8] = old_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  // write path state
  logic [0:0]        w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic              w_oor_q, w_oor_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  // read path state
  logic [1:0]        r_state_q, r_state_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic              r_oor_q, r_oor_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [ADDR_W-1:0] aw_off_s, ar_off_s;
  logic              commit_s, mem_we_s;
  logic [DATA_W-1:0] merged_s, rd_word_s;
  logic              unused_s;

  assign aw_off_s  = word_off(s_axi.S_AXI_AWADDR);
  assign ar_off_s  = word_off(s_axi.S_AXI_ARADDR);
  assign commit_s  = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
  assign mem_we_s  = commit_s && !(ERR_EN && w_oor_q);
  assign merged_s  = merge_bytes(mem_q[w_idx_q], wdata_q, wstrb_q);
  // a write landing on the same edge as a read capture is forwarded
  assign rd_word_s = (mem_we_s && (w_idx_q == r_idx_q)) ? merged_s : mem_q[r_idx_q];
  assign unused_s  = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  // write FSM: latch AW and W independently, commit once both are held
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    w_idx_d   = w_idx_q;
    w_oor_d   = w_oor_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.S_AXI_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          w_idx_d   = aw_off_s[IDX_W-1:0];
          w_oor_d   = |(aw_off_s >> IDX_W);
        end else begin
          aw_held_d = aw_held_q;
        end
        if (s_axi.S_AXI_WVALID && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end else begin
          w_held_d = w_held_q;
        end
        if (commit_s) begin
          bvalid_d  = 1'b1;
          bresp_d   = (ERR_EN && w_oor_q) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // read FSM: latch AR, count down the latency, then hold R until taken
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    r_oor_d   = r_oor_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID && arready_q) begin
          r_idx_d   = ar_off_s[IDX_W-1:0];
          r_oor_d   = |(ar_off_s >> IDX_W);
          r_cnt_d   = RD_CNT_INIT;
          r_state_d = R_WAIT;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          rvalid_d  = 1'b1;
          rdata_d   = (ERR_EN && r_oor_q) ? '0 : rd_word_s;
          rresp_d   = (ERR_EN && r_oor_q) ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end else begin
          r_cnt_d   = r_cnt_q - 4'd1;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // write-path registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      w_idx_q   <= '0;
      w_oor_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      w_idx_q   <= w_idx_d;
      w_oor_q   <= w_oor_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // read-path registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      r_idx_q   <= '0;
      r_oor_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_oor_q   <= r_oor_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // backing memory, no reset so contents persist across ARESETN
  always_ff @(posedge ACLK) begin
    if (mem_we_s) mem_q[w_idx_q] <= merged_s;
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_tb_axil_mem_slave.sv
// Bench for tb_axil_mem_slave: two instances (RD_LAT=1 and RD_LAT=4,
// DEPTH=16) share one master stimulus; responses are checked against
// scoreboard queues filled when each request is issued.
module tb_tb_axil_mem_slave;

  logic        aclk, arst_n;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  int checks   = 0;
  int failures = 0;
  int b_cnt1 = 0, b_cnt4 = 0, r_cnt1 = 0, r_cnt4 = 0;
  bit ev_aw, ev_w, ev_ar;

  logic [1:0]  exp_b1 [$];
  logic [1:0]  exp_b4 [$];
  logic [33:0] exp_r1 [$];
  logic [33:0] exp_r4 [$];

`ifdef TB_AXIL_MEM_ERR_EN
  localparam logic [1:0]  OOR_RESP = 2'b10;
  localparam logic [31:0] OOR_RD0  = 32'h0000_0000;
  localparam logic [31:0] OOR_RD40 = 32'h0000_0000;
`else
  localparam logic [1:0]  OOR_RESP = 2'b00;
  localparam logic [31:0] OOR_RD0  = 32'h0000_0055;
  localparam logic [31:0] OOR_RD40 = 32'h0000_0055;
`endif

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  localparam int NV = 17;
  vec_t tbl [NV];

  tb_axil_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  tb_axil_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();

  assign bus1.S_AXI_AWADDR = awaddr;  assign bus4.S_AXI_AWADDR = awaddr;
  assign bus1.S_AXI_AWPROT = 3'b000;  assign bus4.S_AXI_AWPROT = 3'b000;
  assign bus1.S_AXI_AWVALID = awvalid; assign bus4.S_AXI_AWVALID = awvalid;
  assign bus1.S_AXI_WDATA = wdata;    assign bus4.S_AXI_WDATA = wdata;
  assign bus1.S_AXI_WSTRB = wstrb;    assign bus4.S_AXI_WSTRB = wstrb;
  assign bus1.S_AXI_WVALID = wvalid;  assign bus4.S_AXI_WVALID = wvalid;
  assign bus1.S_AXI_BREADY = bready;  assign bus4.S_AXI_BREADY = bready;
  assign bus1.S_AXI_ARADDR = araddr;  assign bus4.S_AXI_ARADDR = araddr;
  assign bus1.S_AXI_ARPROT = 3'b000;  assign bus4.S_AXI_ARPROT = 3'b000;
  assign bus1.S_AXI_ARVALID = arvalid; assign bus4.S_AXI_ARVALID = arvalid;
  assign bus1.S_AXI_RREADY = rready;  assign bus4.S_AXI_RREADY = rready;

  tb_axil_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE(32'h0), .RD_LAT(1))
    dut1 (.ACLK(aclk), .ARESETN(arst_n), .s_axi(bus1));
  tb_axil_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE(32'h0), .RD_LAT(4))
    dut4 (.ACLK(aclk), .ARESETN(arst_n), .s_axi(bus4));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out waiting for DUT", nm);
  endtask

  // One cycle: observe at negedge (scoreboard pops), then step past posedge.
  task automatic tick();
    logic [1:0]  eb;
    logic [33:0] er;
    @(negedge aclk);
    ev_aw = awvalid && bus1.S_AXI_AWREADY;
    ev_w  = wvalid && bus1.S_AXI_WREADY;
    ev_ar = arvalid && bus1.S_AXI_ARREADY && bus4.S_AXI_ARREADY;
    if (arst_n) begin
      if (bus1.S_AXI_BVALID && bready) begin
        if (exp_b1.size() == 0) timeout("b1_unexpected");
        else begin eb = exp_b1.pop_front(); check("b1_resp", bus1.S_AXI_BRESP, eb); end
        b_cnt1++;
      end
      if (bus4.S_AXI_BVALID && bready) begin
        if (exp_b4.size() == 0) timeout("b4_unexpected");
        else begin eb = exp_b4.pop_front(); check("b4_resp", bus4.S_AXI_BRESP, eb); end
        b_cnt4++;
      end
      if (bus1.S_AXI_RVALID && rready) begin
        if (exp_r1.size() == 0) timeout("r1_unexpected");
        else begin er = exp_r1.pop_front(); check("r1_data_resp", {bus1.S_AXI_RDATA, bus1.S_AXI_RRESP}, er); end
        r_cnt1++;
      end
      if (bus4.S_AXI_RVALID && rready) begin
        if (exp_r4.size() == 0) timeout("r4_unexpected");
        else begin er = exp_r4.pop_front(); check("r4_data_resp", {bus4.S_AXI_RDATA, bus4.S_AXI_RRESP}, er); end
        r_cnt4++;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_dut1"}, {bus1.S_AXI_AWREADY, bus1.S_AXI_WREADY, bus1.S_AXI_ARREADY, bus1.S_AXI_BVALID,
                          bus1.S_AXI_RVALID, bus1.S_AXI_BRESP, bus1.S_AXI_RRESP, bus1.S_AXI_RDATA}, 64'h0);
    check({nm, "_dut4"}, {bus4.S_AXI_AWREADY, bus4.S_AXI_WREADY, bus4.S_AXI_ARREADY, bus4.S_AXI_BVALID,
                          bus4.S_AXI_RVALID, bus4.S_AXI_BRESP, bus4.S_AXI_RRESP, bus4.S_AXI_RDATA}, 64'h0);
  endtask

  task automatic do_reset();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    arst_n = 1'b0;
    tick();
    tick();
    check_zero("rst_outputs");
    @(negedge aclk);
    arst_n = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_ready_dut1", {bus1.S_AXI_AWREADY, bus1.S_AXI_WREADY, bus1.S_AXI_ARREADY}, 3'b111);
    check("rst_ready_dut4", {bus4.S_AXI_AWREADY, bus4.S_AXI_WREADY, bus4.S_AXI_ARREADY}, 3'b111);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    int b1, b4;
    bit aw_done, w_done;
    exp_b1.push_back(er);
    exp_b4.push_back(er);
    b1 = b_cnt1; b4 = b_cnt4;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      tick();
      if (ev_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (ev_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) timeout("wr_aw_w");
    for (int i = 0; i < 20 && !(b_cnt1 != b1 && b_cnt4 != b4); i++) tick();
    if (!(b_cnt1 != b1 && b_cnt4 != b4)) timeout("wr_b");
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int r1, r4, lat1, lat4;
    bit ar_done;
    exp_r1.push_back({ed, er});
    exp_r4.push_back({ed, er});
    r1 = r_cnt1; r4 = r_cnt4;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ar_done = 1'b0;
    for (int i = 0; i < 20 && !ar_done; i++) begin
      tick();
      if (ev_ar) ar_done = 1'b1;
    end
    arvalid = 1'b0;
    if (!ar_done) timeout("rd_ar");
    lat1 = 0; lat4 = 0;
    for (int cyc = 1; cyc <= 20 && !(r_cnt1 != r1 && r_cnt4 != r4); cyc++) begin
      tick();
      if (lat1 == 0 && bus1.S_AXI_RVALID) lat1 = cyc;
      if (lat4 == 0 && bus4.S_AXI_RVALID) lat4 = cyc;
    end
    if (!(r_cnt1 != r1 && r_cnt4 != r4)) timeout("rd_r");
    check("rd_lat_dut1", lat1, 1);
    check("rd_lat_dut4", lat4, 4);
    rready = 1'b0;
  endtask

  initial begin
    int r1, r4;
    bit done, seen;
    tbl[0]  = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    tbl[1]  = '{1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    tbl[2]  = '{1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
    tbl[3]  = '{1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00};
    tbl[4]  = '{1'b0, 32'h20, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
    tbl[5]  = '{1'b1, 32'h04, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
    tbl[6]  = '{1'b1, 32'h04, 32'h0000_9A00, 4'h2, 32'h0,         2'b00};
    tbl[7]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h1234_9A78, 2'b00};
    tbl[8]  = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
    tbl[9]  = '{1'b1, 32'h3C, 32'h0000_0000, 4'h8, 32'h0,         2'b00};
    tbl[10] = '{1'b0, 32'h3C, 32'h0,         4'h0, 32'h00FE_F00D, 2'b00};
    tbl[11] = '{1'b1, 32'h00, 32'h0000_0000, 4'hF, 32'h0,         2'b00};
    tbl[12] = '{1'b1, 32'h40, 32'h0000_0055, 4'hF, 32'h0,         OOR_RESP};
    tbl[13] = '{1'b0, 32'h00, 32'h0,         4'h0, OOR_RD0,       2'b00};
    tbl[14] = '{1'b0, 32'h40, 32'h0,         4'h0, OOR_RD40,      OOR_RESP};
    tbl[15] = '{1'b1, 32'h08, 32'h0BAD_F00D, 4'hF, 32'h0,         2'b00};
    tbl[16] = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b00};

    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    do_reset();

    for (int v = 0; v < NV; v++) begin
      if (tbl[v].is_wr) do_write(tbl[v].addr, tbl[v].data, tbl[v].strb, tbl[v].exp_resp);
      else              do_read(tbl[v].addr, tbl[v].exp_data, tbl[v].exp_resp);
    end

    // W three cycles ahead of AW, then BREADY held low for four cycles
    exp_b1.push_back(2'b00);
    exp_b4.push_back(2'b00);
    r1 = b_cnt1; r4 = b_cnt4;
    wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin tick(); if (ev_w) done = 1'b1; end
    wvalid = 1'b0;
    if (!done) timeout("co_w");
    check("co_after_w", {bus1.S_AXI_WREADY, bus1.S_AXI_AWREADY, bus4.S_AXI_WREADY, bus4.S_AXI_AWREADY}, 4'b0101);
    tick();
    tick();
    awaddr = 32'h30; awvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin tick(); if (ev_aw) done = 1'b1; end
    awvalid = 1'b0;
    if (!done) timeout("co_aw");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("co_b_hold", {bus1.S_AXI_BVALID, bus1.S_AXI_BRESP, bus1.S_AXI_AWREADY, bus1.S_AXI_WREADY,
                          bus4.S_AXI_BVALID, bus4.S_AXI_AWREADY}, 7'b1000010);
    end
    bready = 1'b1;
    for (int i = 0; i < 10 && !(b_cnt1 != r1 && b_cnt4 != r4); i++) tick();
    if (!(b_cnt1 != r1 && b_cnt4 != r4)) timeout("co_b");
    bready = 1'b0;
    check("co_ready_ret", {bus1.S_AXI_AWREADY, bus1.S_AXI_WREADY, bus4.S_AXI_AWREADY, bus4.S_AXI_WREADY}, 4'b1111);
    do_read(32'h30, 32'h5A5A_5A5A, 2'b00);

    // read backpressure: RREADY low for 5 cycles after AR
    exp_r1.push_back({32'hDEAD_BEEF, 2'b00});
    exp_r4.push_back({32'hDEAD_BEEF, 2'b00});
    r1 = r_cnt1; r4 = r_cnt4;
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin tick(); if (ev_ar) done = 1'b1; end
    arvalid = 1'b0;
    if (!done) timeout("bp_ar");
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      check($sformatf("bp_rvalid_c%0d", cyc), bus4.S_AXI_RVALID, (cyc >= 4));
      check("bp_arready_low", {bus1.S_AXI_ARREADY, bus4.S_AXI_ARREADY}, 2'b00);
      if (cyc >= 4) check("bp_rdata_stable", {bus4.S_AXI_RDATA, bus4.S_AXI_RRESP}, {32'hDEAD_BEEF, 2'b00});
    end
    rready = 1'b1;
    for (int i = 0; i < 10 && !(r_cnt1 != r1 && r_cnt4 != r4); i++) tick();
    if (!(r_cnt1 != r1 && r_cnt4 != r4)) timeout("bp_r");
    rready = 1'b0;
    check("bp_arready_ret", {bus1.S_AXI_ARREADY, bus4.S_AXI_ARREADY}, 2'b11);

    // reset between AW and W, then W alone: no response, memory intact
    awaddr = 32'h08; awvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin tick(); if (ev_aw) done = 1'b1; end
    awvalid = 1'b0;
    if (!done) timeout("rm_aw");
    #2 arst_n = 1'b0;
    #1 check_zero("rm_in_reset");
    tick();
    @(negedge aclk);
    arst_n = 1'b1;
    @(posedge aclk);
    #1;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin tick(); if (ev_w) done = 1'b1; end
    wvalid = 1'b0;
    if (!done) timeout("rm_w");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus1.S_AXI_BVALID || bus4.S_AXI_BVALID) seen = 1'b1;
    end
    bready = 1'b0;
    check("rm_no_bvalid", seen, 1'b0);
    do_read(32'h08, 32'h0BAD_F00D, 2'b00);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
